// File: rtl/spie_arb.sv
// spie_arb: four-requester round-robin arbiter in front of a single SPI engine, with chip-select setup/gap timing and burst locking
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   req, req_last      per-requester word request (level) and last-of-burst flag
//   req_data_tx        word for requester i at [32i+31:32i]
//   req_width          data-width code for requester i at [2i+1:2i]
//   req_fast           per-requester fast-speed select
//   req_msbyte         per-requester MSByte-first select
//   grant              one-hot current owner
//   done               one-cycle completion pulse for the owner
//   data_rx            last received word, held until the next completion
//   cs_n               active-low chip selects, index = requester
//   spi_*              engine-side start/config/data handshake
//   timeout            sticky lock-timeout flag (only with SPIE_ARB_TIMEOUT_EN)
//
// Build option: define SPIE_ARB_TIMEOUT_EN to release a lock that idles for 1023 cycles.
module spie_arb #(
    parameter int CS_SETUP = 2,
    parameter int CS_GAP   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [3:0]   req_last,
    input  logic [127:0] req_data_tx,
    input  logic [7:0]   req_width,
    input  logic [3:0]   req_fast,
    input  logic [3:0]   req_msbyte,
    output logic [3:0]   grant,
    output logic [3:0]   done,
    output logic [31:0]  data_rx,
    output logic [3:0]   cs_n,
    output logic         spi_start,
    output logic         spi_fast,
    output logic         spi_msbyte,
    output logic [1:0]   spi_width,
    output logic [31:0]  spi_data_tx,
    input  logic [31:0]  spi_data_rx,
    input  logic         spi_rdy
`ifdef SPIE_ARB_TIMEOUT_EN
    ,
    output logic         timeout
`endif
);
    typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, DONE, LOCK, GAP} state_t;
    // Where a released chip select goes; with no gap the block is immediately idle.
    localparam state_t REL_ST = (CS_GAP == 0) ? IDLE : GAP;
    state_t state, nxt;
    logic [1:0] owner, rr, pick, lane;
    logic [15:0] cnt;
    logic lock_expire;
    // Round robin: scan from rr+1 upward; the loop runs from lowest to highest priority so the last hit wins.
    always_comb begin
        pick = rr;
        for (int k = 4; k >= 1; k--)
            if (req[rr + 2'(k)]) pick = rr + 2'(k);
    end
    assign lane = (state == IDLE) ? pick : owner;
`ifdef SPIE_ARB_TIMEOUT_EN
    // cnt restarts on LOCK entry, so 1022 here is the 1023rd idle LOCK cycle.
    assign lock_expire = (cnt == 16'd1022) && !req[owner];
`else
    assign lock_expire = 1'b0;
`endif
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (|req && spi_rdy) nxt = (CS_SETUP == 0) ? START : SETUP;
            SETUP:   if (cnt == 16'(CS_SETUP - 1)) nxt = START;
            START:   nxt = WAIT;
            // cnt==0 is the first WAIT cycle, where the engine's rdy has not yet dropped.
            WAIT:    if (cnt != 16'd0 && spi_rdy) nxt = DONE;
            DONE:    nxt = req_last[owner] ? REL_ST : LOCK;
            LOCK:    nxt = req[owner] ? START : (lock_expire ? REL_ST : LOCK);
            GAP:     if (cnt == 16'(CS_GAP - 1)) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    assign spi_start = (state == START);
    assign done = (state == DONE) ? grant : 4'b0000;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            owner       <= '0;
            rr          <= 2'd3;
            grant       <= '0;
            cs_n        <= 4'hF;
            data_rx     <= '0;
            spi_fast    <= 1'b0;
            spi_msbyte  <= 1'b0;
            spi_width   <= '0;
            spi_data_tx <= '0;
        end else begin
            state <= nxt;
            cnt   <= (nxt == state) ? cnt + 16'd1 : 16'd0;
            if (state == IDLE && nxt != IDLE) begin
                owner <= pick;
                rr    <= pick;
                grant <= 4'b0001 << pick;
                cs_n  <= ~(4'b0001 << pick);
            end
            if ((state == DONE || state == LOCK) && (nxt == GAP || nxt == IDLE)) begin
                grant <= '0;
                cs_n  <= 4'hF;
            end
            // Engine config is captured on START entry and held until the next START.
            if (nxt == START) begin
                spi_data_tx <= req_data_tx[{lane, 5'd0} +: 32];
                spi_width   <= req_width[{lane, 1'b0} +: 2];
                spi_fast    <= req_fast[lane];
                spi_msbyte  <= req_msbyte[lane];
            end
            if (state == WAIT && nxt == DONE) data_rx <= spi_data_rx;
        end
    end
`ifdef SPIE_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) timeout <= 1'b0;
        else if (state == LOCK && lock_expire) timeout <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_spie_arb.sv
// tb_spie_arb: randomized self-checking bench for spie_arb against a transaction-level round-robin model
module tb_spie_arb;
    localparam int CS_SETUP = 2;
    localparam int CS_GAP   = 2;
    typedef struct packed {
        logic [31:0] d;
        logic        last;
        logic [1:0]  w;
        logic        f;
        logic        m;
    } word_t;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req = '0;
    logic [3:0]   req_last = '0;
    logic [127:0] req_data_tx = '0;
    logic [7:0]   req_width = '0;
    logic [3:0]   req_fast = '0;
    logic [3:0]   req_msbyte = '0;
    logic [3:0]   grant, done, cs_n;
    logic [31:0]  data_rx;
    logic         spi_start, spi_fast, spi_msbyte;
    logic [1:0]   spi_width;
    logic [31:0]  spi_data_tx;
    logic [31:0]  spi_data_rx = '0;
    logic         spi_rdy = 1'b1;
`ifdef SPIE_ARB_TIMEOUT_EN
    logic         timeout;
`endif
    always #5 clk = ~clk;
    spie_arb #(.CS_SETUP(CS_SETUP), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_last(req_last),
        .req_data_tx(req_data_tx), .req_width(req_width), .req_fast(req_fast),
        .req_msbyte(req_msbyte), .grant(grant), .done(done), .data_rx(data_rx),
        .cs_n(cs_n), .spi_start(spi_start), .spi_fast(spi_fast),
        .spi_msbyte(spi_msbyte), .spi_width(spi_width), .spi_data_tx(spi_data_tx),
`ifdef SPIE_ARB_TIMEOUT_EN
        .timeout(timeout),
`endif
        .spi_data_rx(spi_data_rx), .spi_rdy(spi_rdy)
    );
    int errors = 0, checks = 0;
    word_t q[4][$];
    word_t mq[4][$];
    bit    popp[4];
    int st_owner[$], st_setup[$], gaps[$], dn_owner[$];
    logic [31:0] st_data[$], dn_data[$];
    logic [3:0]  st_cfg[$];
    int cfg_bad = 0, inv_bad = 0, cyc = 0, cs_fall = 0, cs_rise_cyc = 0, done_cyc = 0;
    int fixed_lat = 0, busy = 0, mptr = 3;
    bit cs_low_prev, rise_valid, fresh, active;
    logic [35:0] snap;
    int ex_owner[$];
    word_t ex_word[$];
    bit ex_first[$];
    function automatic int oh2i(input logic [3:0] v);
        int r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction
    // Monitor, engine model and requester agents, all sampled 1 ns after each rising edge.
    initial begin
        bit cs_low;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                spi_rdy = 1'b1;
                busy = 0;
                cs_low_prev = 0;
                rise_valid = 0;
                fresh = 0;
                active = 0;
            end else begin
                if (cs_n !== ~grant || $countones(grant) > 1 || (|done && done !== grant) || (spi_start && active)) inv_bad++;
                cs_low = (cs_n !== 4'hF);
                if (cs_low && !cs_low_prev) begin
                    if (rise_valid) gaps.push_back(cyc - cs_rise_cyc);
                    cs_fall = cyc;
                    fresh = 1;
                end
                if (!cs_low && cs_low_prev) begin
                    cs_rise_cyc = cyc;
                    rise_valid = 1;
                end
                if (spi_start) begin
                    st_owner.push_back(oh2i(grant));
                    st_data.push_back(spi_data_tx);
                    st_cfg.push_back({spi_width, spi_fast, spi_msbyte});
                    st_setup.push_back(fresh ? cyc - cs_fall : -1);
                    fresh = 0;
                    snap = {spi_width, spi_fast, spi_msbyte, spi_data_tx};
                    active = 1;
                    busy = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(12, 1));
                    spi_rdy = 1'b0;
                    spi_data_rx = spi_data_tx;
                end else begin
                    if (active && {spi_width, spi_fast, spi_msbyte, spi_data_tx} !== snap) cfg_bad++;
                    if (busy > 0) begin
                        busy--;
                        if (busy == 0) spi_rdy = 1'b1;
                    end
                end
                if (|done) begin
                    dn_owner.push_back(oh2i(done));
                    dn_data.push_back(data_rx);
                    done_cyc = cyc;
                    active = 0;
                end
                cs_low_prev = cs_low;
            end
            for (int i = 0; i < 4; i++) begin
                if (popp[i]) begin
                    q[i].delete(0);
                    popp[i] = 0;
                end
                if (rst_n && done[i]) popp[i] = 1;
                req[i] = (q[i].size() > 0);
                if (q[i].size() > 0) begin
                    req_data_tx[32*i +: 32] = q[i][0].d;
                    req_last[i] = q[i][0].last;
                    req_width[2*i +: 2] = q[i][0].w;
                    req_fast[i] = q[i][0].f;
                    req_msbyte[i] = q[i][0].m;
                end
            end
        end
    end
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    task automatic clear_logs();
        st_owner.delete(); st_setup.delete(); gaps.delete(); dn_owner.delete();
        st_data.delete(); dn_data.delete(); st_cfg.delete();
        cfg_bad = 0; inv_bad = 0; rise_valid = 0;
    endtask
    task automatic push_word(input int i, input word_t w, input bit mdl);
        q[i].push_back(w);
        if (mdl) mq[i].push_back(w);
    endtask
    function automatic word_t rnd_word(input bit last);
        word_t w;
        w.d = $urandom;
        w.last = last;
        w.w = 2'($urandom);
        w.f = 1'($urandom);
        w.m = 1'($urandom);
        return w;
    endfunction
    // Reference: whoever has pending words, taken round-robin after the previous owner, owns the bus for a whole burst.
    task automatic model_predict();
        int i;
        bit first;
        word_t w;
        ex_owner.delete(); ex_word.delete(); ex_first.delete();
        while (mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size() > 0) begin
            i = mptr;
            for (int k = 4; k >= 1; k--) if (mq[(mptr + k) % 4].size() > 0) i = (mptr + k) % 4;
            first = 1;
            do begin
                w = mq[i].pop_front();
                ex_owner.push_back(i);
                ex_word.push_back(w);
                ex_first.push_back(first);
                first = 0;
            end while (!w.last && mq[i].size() > 0);
            mptr = i;
        end
    endtask
    task automatic drain(output bit ok);
        int quiet = 0;
        ok = 0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (q[0].size() + q[1].size() + q[2].size() + q[3].size() == 0 && cs_n === 4'hF && !active) quiet++;
            else quiet = 0;
            if (quiet >= CS_GAP + 4) begin
                ok = 1;
                return;
            end
        end
    endtask
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        mptr = 3;
    endtask
    task automatic test_reset();
        @(posedge clk);
        #2;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b want 0000", done); end
        checks++; if (cs_n !== 4'hF) begin errors++; $display("FAIL reset_cs_n: got %b want 1111", cs_n); end
        checks++; if (spi_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", spi_start); end
        checks++; if (data_rx !== 32'h0) begin errors++; $display("FAIL reset_data_rx: got %h want 0", data_rx); end
`ifdef SPIE_ARB_TIMEOUT_EN
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
`endif
        @(negedge clk);
        rst_n = 1;
    endtask
    task automatic test_single();
        bit ok;
        word_t w;
        clear_logs();
        fixed_lat = 10;
        @(negedge clk);
        w = rnd_word(1'b1);
        w.d = 32'hA5A5_0001;
        push_word(0, w, 1'b1);
        model_predict();
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_drain: not idle within budget"); end
        checks++; if (st_owner.size() != 1 || st_owner[0] != ex_owner[0]) begin errors++; $display("FAIL single_start: starts=%0d owner=%0d want 1 start owner %0d", st_owner.size(), (st_owner.size() > 0) ? st_owner[0] : -1, ex_owner[0]); end
        checks++; if (st_setup.size() != 1 || st_setup[0] != CS_SETUP) begin errors++; $display("FAIL single_setup: got %0d want %0d", (st_setup.size() > 0) ? st_setup[0] : -9, CS_SETUP); end
        checks++; if (dn_owner.size() != 1 || dn_owner[0] != 0) begin errors++; $display("FAIL single_done: pulses=%0d want one on 0", dn_owner.size()); end
        checks++; if (dn_data.size() != 1 || dn_data[0] !== 32'hA5A5_0001) begin errors++; $display("FAIL single_rx: got %h want a5a50001", (dn_data.size() > 0) ? dn_data[0] : 32'hx); end
        checks++; if (data_rx !== 32'hA5A5_0001) begin errors++; $display("FAIL single_hold: got %h want a5a50001", data_rx); end
        checks++; if (cs_n !== 4'hF || grant !== 4'h0) begin errors++; $display("FAIL single_release: cs_n=%b grant=%b want 1111/0000", cs_n, grant); end
        fixed_lat = 0;
    endtask
    task automatic test_round_robin();
        bit ok;
        apply_reset();
        clear_logs();
        @(negedge clk);
        for (int r = 0; r < 2; r++) for (int i = 0; i < 4; i++) push_word(i, rnd_word(1'b1), 1'b1);
        model_predict();
        drain(ok);
        checks++; if (!ok || st_owner.size() != ex_owner.size()) begin errors++; $display("FAIL rr_count: got %0d starts want %0d", st_owner.size(), ex_owner.size()); end
        for (int j = 0; j < st_owner.size() && j < ex_owner.size(); j++) begin
            checks++; if (st_owner[j] != ex_owner[j] || st_owner[j] != j % 4) begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", j, st_owner[j], ex_owner[j]); end
        end
        for (int j = 0; j < gaps.size(); j++) begin
            checks++; if (gaps[j] != CS_GAP + 1) begin errors++; $display("FAIL rr_gap[%0d]: got %0d want %0d", j, gaps[j], CS_GAP + 1); end
        end
        checks++; if (inv_bad != 0) begin errors++; $display("FAIL rr_onehot: got %0d bad cycles want 0", inv_bad); end
    endtask
    task automatic test_burst();
        bit ok;
        int c;
        word_t w[3];
        word_t w1;
        int exp_own[4] = '{2, 2, 2, 1};
        int exp_set[4] = '{CS_SETUP, -1, -1, CS_SETUP};
        clear_logs();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            w[k] = rnd_word(k == 2);
            push_word(2, w[k], 1'b0);
        end
        w1 = rnd_word(1'b1);
        for (c = 0; c < 50 && grant !== 4'b0100; c++) @(negedge clk);
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL burst_grant: got %b want 0100", grant); end
        push_word(1, w1, 1'b0);
        drain(ok);
        mptr = 1;
        checks++; if (!ok || st_owner.size() != 4) begin errors++; $display("FAIL burst_count: got %0d starts want 4", st_owner.size()); end
        for (int j = 0; j < 4 && j < st_owner.size(); j++) begin
            checks++; if (st_owner[j] != exp_own[j] || st_setup[j] != exp_set[j] || st_data[j] !== ((j < 3) ? w[j].d : w1.d)) begin errors++; $display("FAIL burst_word[%0d]: owner=%0d setup=%0d data=%h want %0d/%0d/%h", j, st_owner[j], st_setup[j], st_data[j], exp_own[j], exp_set[j], (j < 3) ? w[j].d : w1.d); end
        end
        checks++; if (gaps.size() != 1 || gaps[0] != CS_GAP + 1) begin errors++; $display("FAIL burst_gap: got %0d gaps first=%0d want 1 of %0d", gaps.size(), (gaps.size() > 0) ? gaps[0] : -1, CS_GAP + 1); end
        checks++; if (inv_bad != 0 || cfg_bad != 0) begin errors++; $display("FAIL burst_invariant: inv=%0d cfg=%0d want 0/0", inv_bad, cfg_bad); end
    endtask
    task automatic test_config();
        bit ok;
        word_t w;
        clear_logs();
        fixed_lat = 8;
        @(negedge clk);
        w = rnd_word(1'b1);
        w.w = 2'b10; w.f = 1'b0; w.m = 1'b1;
        push_word(3, w, 1'b1);
        model_predict();
        drain(ok);
        checks++; if (!ok || st_owner.size() != 1 || st_owner[0] != 3) begin errors++; $display("FAIL cfg_owner: starts=%0d want one on 3", st_owner.size()); end
        checks++; if (st_cfg.size() != 1 || st_cfg[0] !== 4'b1001) begin errors++; $display("FAIL cfg_value: got %b want 1001", (st_cfg.size() > 0) ? st_cfg[0] : 4'hx); end
        checks++; if (cfg_bad != 0) begin errors++; $display("FAIL cfg_stable: got %0d changes want 0", cfg_bad); end
        checks++; if (dn_data.size() != 1 || dn_data[0] !== w.d) begin errors++; $display("FAIL cfg_rx: got %h want %h", (dn_data.size() > 0) ? dn_data[0] : 32'hx, w.d); end
        fixed_lat = 0;
    endtask
    task automatic test_random();
        bit ok;
        int nb, len;
        for (int r = 0; r < 3; r++) begin
            clear_logs();
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                nb = $urandom_range(2, 0);
                for (int b = 0; b < nb; b++) begin
                    len = $urandom_range(3, 1);
                    for (int k = 0; k < len; k++) push_word(i, rnd_word(k == len - 1), 1'b1);
                end
            end
            model_predict();
            drain(ok);
            checks++; if (!ok || st_owner.size() != ex_owner.size() || dn_owner.size() != ex_owner.size()) begin errors++; $display("FAIL rand_count: starts=%0d dones=%0d want %0d", st_owner.size(), dn_owner.size(), ex_owner.size()); end
            for (int j = 0; j < ex_owner.size() && j < st_owner.size() && j < dn_owner.size(); j++) begin
                checks++;
                if (st_owner[j] != ex_owner[j] || st_data[j] !== ex_word[j].d || st_cfg[j] !== {ex_word[j].w, ex_word[j].f, ex_word[j].m} || st_setup[j] != (ex_first[j] ? CS_SETUP : -1) || dn_owner[j] != ex_owner[j] || dn_data[j] !== ex_word[j].d) begin
                    errors++;
                    $display("FAIL rand_word[%0d]: owner=%0d data=%h cfg=%b setup=%0d done=%0d rx=%h want %0d/%h/%b/%0d", j, st_owner[j], st_data[j], st_cfg[j], st_setup[j], dn_owner[j], dn_data[j], ex_owner[j], ex_word[j].d, {ex_word[j].w, ex_word[j].f, ex_word[j].m}, ex_first[j] ? CS_SETUP : -1);
                end
            end
            for (int j = 0; j < gaps.size(); j++) begin
                checks++; if (gaps[j] != CS_GAP + 1) begin errors++; $display("FAIL rand_gap[%0d]: got %0d want %0d", j, gaps[j], CS_GAP + 1); end
            end
            checks++; if (inv_bad != 0 || cfg_bad != 0) begin errors++; $display("FAIL rand_invariant: inv=%0d cfg=%0d want 0/0", inv_bad, cfg_bad); end
        end
    endtask
    task automatic test_reset_mid();
        bit ok;
        int c;
        clear_logs();
        fixed_lat = 20;
        @(negedge clk);
        push_word(2, rnd_word(1'b1), 1'b0);
        for (c = 0; c < 50 && st_owner.size() == 0; c++) @(negedge clk);
        checks++; if (st_owner.size() == 0) begin errors++; $display("FAIL rstmid_start: no start seen"); end
        repeat (3) @(negedge clk);
        rst_n = 0;
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            popp[i] = 0;
        end
        #1;
        checks++; if (cs_n !== 4'hF || grant !== 4'h0) begin errors++; $display("FAIL rstmid_async: cs_n=%b grant=%b want 1111/0000", cs_n, grant); end
        @(negedge clk);
        rst_n = 1;
        mptr = 3;
        repeat (3) @(negedge clk);
        checks++; if (dn_owner.size() != 0 || data_rx !== 32'h0) begin errors++; $display("FAIL rstmid_nodone: dones=%0d data_rx=%h want 0/0", dn_owner.size(), data_rx); end
        clear_logs();
        fixed_lat = 0;
        push_word(3, rnd_word(1'b1), 1'b1);
        push_word(0, rnd_word(1'b1), 1'b1);
        model_predict();
        drain(ok);
        checks++; if (!ok || st_owner.size() != 2 || st_owner[0] != ex_owner[0] || st_owner[1] != ex_owner[1]) begin errors++; $display("FAIL rstmid_next: starts=%0d first=%0d want 2 starting at %0d", st_owner.size(), (st_owner.size() > 0) ? st_owner[0] : -1, ex_owner[0]); end
    endtask
`ifdef SPIE_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int c;
        clear_logs();
        fixed_lat = 3;
        @(negedge clk);
        push_word(1, rnd_word(1'b0), 1'b0);
        for (c = 0; c < 100 && dn_owner.size() == 0; c++) @(negedge clk);
        checks++; if (dn_owner.size() != 1) begin errors++; $display("FAIL to_done: got %0d dones want 1", dn_owner.size()); end
        repeat (500) @(negedge clk);
        checks++; if (cs_n !== 4'b1101 || timeout !== 1'b0) begin errors++; $display("FAIL to_locked: cs_n=%b timeout=%b want 1101/0", cs_n, timeout); end
        for (c = 0; c < 1200 && cs_n !== 4'hF; c++) @(negedge clk);
        checks++; if (cs_rise_cyc - done_cyc != 1024) begin errors++; $display("FAIL to_release: got %0d cycles after done want 1024", cs_rise_cyc - done_cyc); end
        repeat (20) @(negedge clk);
        checks++; if (timeout !== 1'b1 || grant !== 4'h0) begin errors++; $display("FAIL to_sticky: timeout=%b grant=%b want 1/0000", timeout, grant); end
        apply_reset();
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", timeout); end
        fixed_lat = 0;
    endtask
`endif
    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_config();
        test_random();
        test_reset_mid();
`ifdef SPIE_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
